mem_access_unit: RTL and testbench

//  Data-side responder for the MEM-stage control word (mem_read, mem_write, data_size,

---
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-side load/store responder: turns one MEM-stage request into a single
// data-SRAM transaction, with lane steering, load extension and AdEL/AdES.
module mem_access_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  data_size,
  input  logic        data_ext_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic [31:0] badvaddr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // WAIT lasts READ_LATENCY-1 cycles; the counter runs 0..WAIT_LAST.
  localparam int unsigned WAIT_CYCLES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [1:0]  WAIT_LAST   = 2'(WAIT_CYCLES - 1);

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  state_t      r_state;
  state_t      w_next;
  logic        r_is_store;
  logic        r_is_load;
  logic [1:0]  r_size;
  logic        r_zext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_exc;
  logic [1:0]  r_cnt;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_exc;
  logic        w_noop;
  logic        w_capture;
  logic [3:0]  w_lane_wen;
  logic [31:0] w_lane_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign w_accept     = req_valid && (r_state == S_IDLE);
  assign w_misaligned = ((data_size == 2'b01) && addr[0]) ||
                        (data_size[1] && (addr[1:0] != 2'b00));
  assign w_noop       = !mem_read && !mem_write;
  assign w_exc        = !w_noop && w_misaligned;

  // Load data is sampled on the edge that leaves the last SRAM-latency cycle.
  assign w_capture = (w_next == S_RESP) &&
                     ((r_state == S_WAIT) || (r_state == S_ISSUE && r_is_load));

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_exc || w_noop) ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = (r_is_store || READ_LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == WAIT_LAST) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_is_load  <= 1'b0;
      r_size     <= 2'b00;
      r_zext     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_exc      <= 1'b0;
      r_cnt      <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_is_store <= mem_write;
        r_is_load  <= mem_read && !mem_write;
        r_size     <= data_size;
        r_zext     <= data_ext_type;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_exc      <= w_exc;
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt + 2'd1;
      else                   r_cnt <= '0;
      if (w_capture) r_rdata <= data_sram_rdata;
    end
  end

  always_comb begin
    w_lane_wen   = 4'hF;
    w_lane_wdata = r_wdata;
    unique case (r_size)
      2'b00: begin
        w_lane_wen   = 4'b0001 << r_addr[1:0];
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_lane_wen   = 4'b0011 << r_addr[1:0];
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane_wen   = 4'hF;
        w_lane_wdata = r_wdata;
      end
    endcase
  end

  assign w_byte = r_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_ext = r_rdata;
    unique case (r_size)
      2'b00:   w_load_ext = r_zext ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = r_zext ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = r_rdata;
    endcase
  end

  always_comb begin
    req_ready       = (r_state == S_IDLE);
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    resp_valid      = 1'b0;
    resp_rdata      = '0;
    resp_exc        = 1'b0;
    resp_exc_code   = 5'h00;
    badvaddr        = '0;
    if (r_state == S_ISSUE) begin
      data_sram_en   = 1'b1;
      data_sram_addr = {r_addr[31:2], 2'b00};
      if (r_is_store) begin
        data_sram_wen   = w_lane_wen;
        data_sram_wdata = w_lane_wdata;
      end
    end
    if (r_state == S_RESP) begin
      resp_valid = 1'b1;
      resp_exc   = r_exc;
      if (r_exc) begin
        resp_exc_code = r_is_store ? EXC_ADES : EXC_ADEL;
        badvaddr      = r_addr;
      end else if (r_is_load) begin
        resp_rdata = w_load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: two units (READ_LATENCY 1 and 3) against a byte-addressed
// reference memory model plus directed latency, exception and reset scenarios.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v     [2];
  logic        req_valid_v [2];
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  data_size;
  logic        data_ext_type;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        req_ready_v  [2];
  logic        en_v         [2];
  logic [3:0]  wen_v        [2];
  logic [31:0] saddr_v      [2];
  logic [31:0] swdata_v     [2];
  logic [31:0] srdata_v     [2];
  logic        resp_valid_v [2];
  logic [31:0] resp_rdata_v [2];
  logic        resp_exc_v   [2];
  logic [4:0]  code_v       [2];
  logic [31:0] badv_v       [2];

  mem_access_unit #(.READ_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .mem_read(mem_read), .mem_write(mem_write), .data_size(data_size),
    .data_ext_type(data_ext_type), .addr(addr), .wdata(wdata),
    .data_sram_en(en_v[0]), .data_sram_wen(wen_v[0]), .data_sram_addr(saddr_v[0]),
    .data_sram_wdata(swdata_v[0]), .data_sram_rdata(srdata_v[0]),
    .resp_valid(resp_valid_v[0]), .resp_rdata(resp_rdata_v[0]), .resp_exc(resp_exc_v[0]),
    .resp_exc_code(code_v[0]), .badvaddr(badv_v[0])
  );

  mem_access_unit #(.READ_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .mem_read(mem_read), .mem_write(mem_write), .data_size(data_size),
    .data_ext_type(data_ext_type), .addr(addr), .wdata(wdata),
    .data_sram_en(en_v[1]), .data_sram_wen(wen_v[1]), .data_sram_addr(saddr_v[1]),
    .data_sram_wdata(swdata_v[1]), .data_sram_rdata(srdata_v[1]),
    .resp_valid(resp_valid_v[1]), .resp_rdata(resp_rdata_v[1]), .resp_exc(resp_exc_v[1]),
    .resp_exc_code(code_v[1]), .badvaddr(badv_v[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int rl(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  // SRAM model: 16 words per unit, read data valid only in cycle en+RL-1.
  logic [31:0] sram_mem [2][16];
  logic [31:0] ref_mem  [2][16];
  bit          rd_pend  [2];
  int          rd_cd    [2];
  logic [31:0] rd_data  [2];

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (en_v[i] && wen_v[i] != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (wen_v[i][b]) sram_mem[i][saddr_v[i][5:2]][8*b +: 8] = swdata_v[i][8*b +: 8];
      end else if (en_v[i]) begin
        rd_pend[i] = 1'b1;
        rd_cd[i]   = rl(i) - 1;
        rd_data[i] = sram_mem[i][saddr_v[i][5:2]];
      end else if (rd_pend[i]) begin
        rd_cd[i]--;
      end
      if (rd_pend[i] && rd_cd[i] == 0) begin
        srdata_v[i] = rd_data[i];
        rd_pend[i]  = 1'b0;
      end else begin
        srdata_v[i] = $urandom;
      end
    end
  end

  typedef struct {
    int          lat;
    int          ens;
    int          en_k;
    int          pulses;
    int          stray;
    int          rdy_bad;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wen;
    logic [31:0] rdata;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badv;
  } obs_t;

  typedef struct {
    int          lat;
    int          ens;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] rdata;
    logic [31:0] badv;
  } exp_t;

  // Reference: byte-addressed memory, access size in bytes, alignment by modulo.
  function automatic exp_t model(input int idx, input logic rd, input logic wr,
                                 input logic [1:0] sz, input logic zext,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic [31:0] v;
    logic [31:0] ba;
    e = '{lat: 1, ens: 0, exc: 1'b0, code: 5'h0, rdata: 32'h0, badv: 32'h0};
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    v = 32'h0;
    if (!rd && !wr) begin
      e.lat = 1;
    end else if ((a % n) != 0) begin
      e.exc  = 1'b1;
      e.code = wr ? 5'h05 : 5'h04;
      e.badv = a;
    end else begin
      e.ens = 1;
      for (int j = 0; j < n; j++) begin
        ba = a + 32'(j);
        if (wr) ref_mem[idx][ba[5:2]][8*int'(ba[1:0]) +: 8] = wd[8*j +: 8];
        else    v[8*j +: 8] = ref_mem[idx][ba[5:2]][8*int'(ba[1:0]) +: 8];
      end
      if (wr) begin
        e.lat = 2;
      end else begin
        e.lat = 1 + rl(idx);
        if (!zext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Issues one request and records what the unit does over the next 8 cycles.
  task automatic do_req(input int idx, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic zext, input logic [31:0] a, input logic [31:0] wd,
                        output obs_t o);
    int w;
    o = '{lat: -1, ens: 0, en_k: -1, pulses: 0, stray: 0, rdy_bad: 0, i_addr: 32'h0,
          i_wdata: 32'h0, i_wen: 4'h0, rdata: 32'h0, exc: 1'b0, code: 5'h0, badv: 32'h0};
    w = 0;
    @(negedge clk);
    while (!req_ready_v[idx] && w < 20) begin
      @(negedge clk);
      w++;
    end
    mem_read = rd; mem_write = wr; data_size = sz; data_ext_type = zext;
    addr = a; wdata = wd;
    req_valid_v[idx] = 1'b1;
    @(posedge clk);
    #1 req_valid_v[idx] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (en_v[idx]) begin
        o.ens++;
        if (o.en_k < 0) o.en_k = k;
        o.i_addr = saddr_v[idx]; o.i_wen = wen_v[idx]; o.i_wdata = swdata_v[idx];
      end else if (wen_v[idx] != 0 || saddr_v[idx] != 0 || swdata_v[idx] != 0) begin
        o.stray++;
      end
      if (resp_valid_v[idx]) begin
        o.pulses++;
        if (o.lat < 0) begin
          o.lat = k; o.rdata = resp_rdata_v[idx]; o.exc = resp_exc_v[idx];
          o.code = code_v[idx]; o.badv = badv_v[idx];
        end
      end else if (resp_rdata_v[idx] != 0 || resp_exc_v[idx] || code_v[idx] != 0 ||
                   badv_v[idx] != 0) begin
        o.stray++;
      end
      if (req_ready_v[idx] !== (o.lat >= 0 && k > o.lat)) o.rdy_bad++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({req_ready_v[i], en_v[i], wen_v[i], saddr_v[i], swdata_v[i], resp_valid_v[i],
           resp_rdata_v[i], resp_exc_v[i], code_v[i], badv_v[i]} !== {1'b1, 140'h0}) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: ready=%b en=%b wen=%h rv=%b rdata=%h exc=%b, need ready=1 rest 0",
                 i, req_ready_v[i], en_v[i], wen_v[i], resp_valid_v[i], resp_rdata_v[i], resp_exc_v[i]);
      end
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    exp_t e;
    e = model(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hA5);
    do_req(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hA5, o);
    n_checks++;
    if (o.en_k !== 1 || o.ens !== 1) begin
      n_fail++; $display("FAIL sb_en: en_k=%0d ens=%0d, need 1 1", o.en_k, o.ens);
    end
    n_checks++;
    if ({o.i_wen, o.i_wdata, o.i_addr} !== {4'b1000, 32'hA5A5_A5A5, 32'h100}) begin
      n_fail++;
      $display("FAIL sb_issue: wen=%b wdata=%h addr=%h, need 1000 a5a5a5a5 00000100",
               o.i_wen, o.i_wdata, o.i_addr);
    end
    n_checks++;
    if (o.lat !== e.lat || o.rdata !== 32'h0 || o.pulses !== 1) begin
      n_fail++;
      $display("FAIL sb_resp: lat=%0d rdata=%h pulses=%0d, need lat=2 rdata=0 pulses=1",
               o.lat, o.rdata, o.pulses);
    end
    n_checks++;
    if (o.stray !== 0 || o.rdy_bad !== 0) begin
      n_fail++; $display("FAIL sb_idle_outputs: stray=%0d rdy_bad=%0d, need 0 0", o.stray, o.rdy_bad);
    end
  endtask

  task automatic test_load_half();
    obs_t o;
    exp_t e;
    sram_mem[0][0] = 32'h8001_1234;
    ref_mem[0][0]  = 32'h8001_1234;
    e = model(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0);
    do_req(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, o);
    n_checks++;
    if (o.lat !== 2 || o.rdata !== 32'hFFFF_8001 || o.rdata !== e.rdata) begin
      n_fail++; $display("FAIL lh: lat=%0d rdata=%h, need 2 ffff8001", o.lat, o.rdata);
    end
    do_req(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, o);
    n_checks++;
    if (o.lat !== 2 || o.rdata !== 32'h0000_8001 || o.i_wen !== 4'h0) begin
      n_fail++; $display("FAIL lhu: lat=%0d rdata=%h wen=%h, need 2 00008001 0", o.lat, o.rdata, o.i_wen);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h301, 32'h0, o);
    n_checks++;
    if ({o.exc, o.code, o.badv} !== {1'b1, 5'h04, 32'h301} || o.lat !== 1 || o.ens !== 0) begin
      n_fail++;
      $display("FAIL lw_adel: exc=%b code=%h badv=%h lat=%0d ens=%0d, need 1 04 301 1 0",
               o.exc, o.code, o.badv, o.lat, o.ens);
    end
    do_req(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h305, 32'h1234, o);
    n_checks++;
    if ({o.exc, o.code, o.badv} !== {1'b1, 5'h05, 32'h305} || o.lat !== 1 || o.ens !== 0) begin
      n_fail++;
      $display("FAIL sh_ades: exc=%b code=%h badv=%h lat=%0d ens=%0d, need 1 05 305 1 0",
               o.exc, o.code, o.badv, o.lat, o.ens);
    end
  endtask

  task automatic test_latency3();
    obs_t o;
    sram_mem[1][0] = 32'hC000_0000;
    ref_mem[1][0]  = 32'hC000_0000;
    do_req(1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, o);
    n_checks++;
    if (o.ens !== 1 || o.en_k !== 1) begin
      n_fail++; $display("FAIL lbu_rl3_en: ens=%0d en_k=%0d, need 1 1", o.ens, o.en_k);
    end
    n_checks++;
    if (o.lat !== 4 || o.rdata !== 32'h0000_00C0 || o.pulses !== 1) begin
      n_fail++;
      $display("FAIL lbu_rl3_resp: lat=%0d rdata=%h pulses=%0d, need 4 000000c0 1",
               o.lat, o.rdata, o.pulses);
    end
  endtask

  task automatic test_back_to_back();
    int   acc;
    int   pulses;
    int   acc_c [3];
    exp_t e;
    logic [31:0] wd;
    wd = $urandom;
    for (int j = 0; j < 3; j++) e = model(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, wd);
    acc = 0; pulses = 0; acc_c = '{-1, -1, -1};
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b1; data_size = 2'b10; data_ext_type = 1'b0;
    addr = 32'h10; wdata = wd;
    req_valid_v[0] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid_v[0]) pulses++;
      if (acc == 3) req_valid_v[0] = 1'b0;
      else if (req_ready_v[0]) begin
        acc_c[acc] = c;
        acc++;
      end
    end
    req_valid_v[0] = 1'b0;
    n_checks++;
    if (acc !== 3 || acc_c[0] !== 0 || acc_c[1] !== 3 || acc_c[2] !== 6) begin
      n_fail++;
      $display("FAIL b2b_accepts: count=%0d at %0d,%0d,%0d, need 3 at 0,3,6",
               acc, acc_c[0], acc_c[1], acc_c[2]);
    end
    n_checks++;
    if (pulses !== 3) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d, need 3", pulses);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int   pulses;
    pulses = 0;
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; data_size = 2'b10; data_ext_type = 1'b0;
    addr = 32'h8; wdata = 32'h0;
    req_valid_v[1] = 1'b1;
    @(posedge clk);
    #1 req_valid_v[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_v[1] = 1'b1;
    #1;
    n_checks++;
    if ({req_ready_v[1], en_v[1], wen_v[1], saddr_v[1], swdata_v[1], resp_valid_v[1],
         resp_rdata_v[1], resp_exc_v[1], code_v[1], badv_v[1]} !== {1'b1, 140'h0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: ready=%b en=%b rv=%b rdata=%h, need ready=1 rest 0",
               req_ready_v[1], en_v[1], resp_valid_v[1], resp_rdata_v[1]);
    end
    @(negedge clk);
    @(negedge clk);
    reset_v[1] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid_v[1] || !req_ready_v[1]) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL midreset_dropped: %0d cycles with resp or not ready, need 0", pulses);
    end
    e = model(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    do_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, o);
    n_checks++;
    if (o.lat !== e.lat || o.rdata !== e.rdata || o.pulses !== 1) begin
      n_fail++;
      $display("FAIL midreset_next_lw: lat=%0d rdata=%h pulses=%0d, need %0d %h 1",
               o.lat, o.rdata, o.pulses, e.lat, e.rdata);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    int          idx;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        zext;
    logic [31:0] a;
    logic [31:0] wd;
    for (int t = 0; t < 80; t++) begin
      idx  = int'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin rd = 1'b0; wr = 1'b0; end
      else if (!rd && !wr) rd = 1'b1;
      sz   = 2'($urandom_range(0, 3));
      zext = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wd   = $urandom;
      e = model(idx, rd, wr, sz, zext, a, wd);
      do_req(idx, rd, wr, sz, zext, a, wd, o);
      n_checks++;
      if (o.lat !== e.lat || o.ens !== e.ens || o.pulses !== 1) begin
        n_fail++;
        $display("FAIL rand_timing t=%0d u%0d rd=%b wr=%b sz=%0d a=%h: lat=%0d ens=%0d pulses=%0d, need %0d %0d 1",
                 t, idx, rd, wr, sz, a, o.lat, o.ens, o.pulses, e.lat, e.ens);
      end
      n_checks++;
      if ({o.rdata, o.exc, o.code, o.badv} !== {e.rdata, e.exc, e.code, e.badv}) begin
        n_fail++;
        $display("FAIL rand_resp t=%0d u%0d rd=%b wr=%b sz=%0d ext=%b a=%h: rdata=%h exc=%b code=%h badv=%h, need %h %b %h %h",
                 t, idx, rd, wr, sz, zext, a, o.rdata, o.exc, o.code, o.badv,
                 e.rdata, e.exc, e.code, e.badv);
      end
      n_checks++;
      if (o.stray !== 0 || o.rdy_bad !== 0) begin
        n_fail++;
        $display("FAIL rand_idle_outputs t=%0d u%0d: stray=%0d rdy_bad=%0d, need 0 0",
                 t, idx, o.stray, o.rdy_bad);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      reset_v[i] = 1'b1; req_valid_v[i] = 1'b0; rd_pend[i] = 1'b0; rd_cd[i] = 0;
      rd_data[i] = 32'h0;
      for (int w = 0; w < 16; w++) begin
        sram_mem[i][w] = $urandom;
        ref_mem[i][w]  = sram_mem[i][w];
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; data_size = 2'b00; data_ext_type = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_v[0] = 1'b0;
    reset_v[1] = 1'b0;
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_latency3();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
